// File: rtl/irq_pkg.sv
// Shared types and config register map for the interrupt controller.
package irq_pkg;

    typedef enum logic {IDLE, BUSY} irq_state_e;

    localparam logic [1:0] CFG_ENABLE   = 2'd0;
    localparam logic [1:0] CFG_EDGE_SEL = 2'd1;
    localparam logic [1:0] CFG_SW_SET   = 2'd2;

endpackage

// File: rtl/irq_if.sv
// Source, config and claim/complete signals between the core side and the controller.
interface irq_if #(
    parameter int N = 4
);
    localparam int S = 2**N;

    logic [S-1:0] irq_src;
    logic         cfg_we;
    logic [1:0]   cfg_addr;
    logic [S-1:0] cfg_wdata;
    logic         irq;
    logic         claim_req;
    logic         claim_ack;
    logic         claim_hit;
    logic [N-1:0] claim_id;
    logic         complete_req;
    logic [N-1:0] complete_id;

    modport master (
        output irq_src, cfg_we, cfg_addr, cfg_wdata, claim_req, complete_req, complete_id,
        input  irq, claim_ack, claim_hit, claim_id
    );

    modport slave (
        input  irq_src, cfg_we, cfg_addr, cfg_wdata, claim_req, complete_req, complete_id,
        output irq, claim_ack, claim_hit, claim_id
    );

endinterface

// File: rtl/priority_encoder.sv
// 2**N -> N priority encoder; the highest set index wins.
module priority_encoder #(
    parameter int N = 4
) (
    input  logic [2**N-1:0] req_i,
    output logic [N-1:0]    id_o,
    output logic            valid_o
);

    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = 0; i < 2**N; i++) begin
            if (req_i[i]) begin
                id_o    = N'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/enable/edge-select registers, fixed-priority pick
// and a claim/complete FSM that keeps one source in service at a time.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    irq_if.slave bus
);

    localparam int S = 2**N;

    logic [S-1:0] enable_q, edge_sel_q, src_q;
    logic [S-1:0] pending_q, pending_d;
    logic [S-1:0] cand, set_term, clr_term, sw_set;
    logic [N-1:0] enc_id;
    logic         enc_valid;

    irq_state_e   state_q, state_d;
    logic [N-1:0] active_id_q, active_id_d;
    logic         ack_q, ack_d, hit_q, hit_d;
    logic [N-1:0] id_q, id_d;
    logic         irq_w, claim_grant;

    assign cand = pending_q & enable_q;

    priority_encoder #(.N(N)) u_enc (
        .req_i   (cand),
        .id_o    (enc_id),
        .valid_o (enc_valid)
    );

    // Level bits follow the line; edge bits hold until claimed. Set wins over clear.
    assign set_term  = (bus.irq_src & ~edge_sel_q) | (bus.irq_src & ~src_q & edge_sel_q);
    assign sw_set    = (bus.cfg_we && bus.cfg_addr == CFG_SW_SET) ? bus.cfg_wdata : '0;
    assign clr_term  = claim_grant ? (edge_sel_q & (S'(1) << enc_id)) : '0;
    assign pending_d = (pending_q & edge_sel_q & ~clr_term) | set_term | sw_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= '0;
            edge_sel_q <= '0;
            src_q      <= '0;
            pending_q  <= '0;
        end else begin
            src_q     <= bus.irq_src;
            pending_q <= pending_d;
            if (bus.cfg_we && bus.cfg_addr == CFG_ENABLE)   enable_q   <= bus.cfg_wdata;
            if (bus.cfg_we && bus.cfg_addr == CFG_EDGE_SEL) edge_sel_q <= bus.cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            active_id_q <= '0;
            ack_q       <= 1'b0;
            hit_q       <= 1'b0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            active_id_q <= active_id_d;
            ack_q       <= ack_d;
            hit_q       <= hit_d;
            id_q        <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.claim_req && enc_valid) state_d = BUSY;
            BUSY: if (bus.complete_req && bus.complete_id == active_id_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Claims only win from IDLE, so a claim alongside a complete in BUSY acks empty.
    always_comb begin
        irq_w       = (state_q == IDLE) && enc_valid;
        claim_grant = (state_q == IDLE) && bus.claim_req && enc_valid;
        ack_d       = bus.claim_req;
        hit_d       = claim_grant;
        id_d        = claim_grant ? enc_id : '0;
        active_id_d = claim_grant ? enc_id : active_id_q;
    end

    assign bus.irq       = irq_w;
    assign bus.claim_ack = ack_q;
    assign bus.claim_hit = hit_q;
    assign bus.claim_id  = id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: vector table, directed corner cases, random vs model.
module tb_irq_controller;
    import irq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    irq_if #(.N(4)) bus ();
    irq_controller #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] en;
        logic [15:0] sw;
        logic        exp_irq;
        logic        exp_hit;
        logic [3:0]  exp_id;
    } vec_t;

    vec_t vecs[8];

    // model state
    bit m_pend[16], m_en[16], m_edge[16], m_prev[16];
    bit m_busy;
    int m_act;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
        bus.claim_req = 1'b0; bus.complete_req = 1'b0; bus.complete_id = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.irq_src = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
        tick();
        bus.cfg_we = 1'b0; bus.cfg_wdata = '0;
    endtask

    task automatic claim();
        bus.claim_req = 1'b1;
        tick();
        bus.claim_req = 1'b0;
    endtask

    task automatic complete(input logic [3:0] id);
        bus.complete_req = 1'b1; bus.complete_id = id;
        tick();
        bus.complete_req = 1'b0;
    endtask

    task automatic chk_claim(input string name, input logic hit, input logic [3:0] id);
        chk({name, "_ack"}, bus.claim_ack, 1);
        chk({name, "_hit"}, bus.claim_hit, hit);
        chk({name, "_id"}, bus.claim_id, id);
    endtask

    initial begin
        vecs[0] = '{16'hffff, 16'h0001, 1'b1, 1'b1, 4'd0};
        vecs[1] = '{16'hffff, 16'h8001, 1'b1, 1'b1, 4'd15};
        vecs[2] = '{16'h00ff, 16'h8001, 1'b1, 1'b1, 4'd0};
        vecs[3] = '{16'h0000, 16'hffff, 1'b0, 1'b0, 4'd0};
        vecs[4] = '{16'h0f00, 16'h0a50, 1'b1, 1'b1, 4'd11};
        vecs[5] = '{16'hffff, 16'h0000, 1'b0, 1'b0, 4'd0};
        vecs[6] = '{16'hf0f0, 16'h0f0f, 1'b0, 1'b0, 4'd0};
        vecs[7] = '{16'h3000, 16'h1000, 1'b1, 1'b1, 4'd12};

        do_reset();
        chk("rst_irq", bus.irq, 0);
        chk("rst_ack", bus.claim_ack, 0);
        chk("rst_hit", bus.claim_hit, 0);
        chk("rst_id", bus.claim_id, 0);

        // table: edge mode everywhere so SW_SET bits stay pending
        for (int v = 0; v < 8; v++) begin
            do_reset();
            cfg_write(CFG_EDGE_SEL, 16'hffff);
            cfg_write(CFG_ENABLE, vecs[v].en);
            cfg_write(CFG_SW_SET, vecs[v].sw);
            chk($sformatf("vec%0d_irq", v), bus.irq, vecs[v].exp_irq);
            claim();
            chk_claim($sformatf("vec%0d", v), vecs[v].exp_hit, vecs[v].exp_id);
        end

        // 1: level sources 3 and 5
        do_reset();
        cfg_write(CFG_ENABLE, 16'h0028);
        bus.irq_src = 16'h0028;
        tick();
        chk("t1_irq", bus.irq, 1);
        claim();
        chk_claim("t1_claim", 1, 5);
        chk("t1_busy_irq", bus.irq, 0);
        complete(4'd5);
        chk("t1_reirq", bus.irq, 1);
        claim();
        chk_claim("t1_claim2", 1, 5);
        bus.irq_src = '0;
        complete(4'd5);
        chk("t1_drop_irq", bus.irq, 0);

        // 2: edge pulse on 2 while masked
        cfg_write(CFG_ENABLE, 16'h0000);
        cfg_write(CFG_EDGE_SEL, 16'h0004);
        bus.irq_src = 16'h0004;
        tick();
        bus.irq_src = '0;
        tick();
        chk("t2_masked", bus.irq, 0);
        cfg_write(CFG_ENABLE, 16'h0004);
        chk("t2_unmask", bus.irq, 1);
        claim();
        chk_claim("t2_claim", 1, 2);
        complete(4'd2);
        chk("t2_cleared", bus.irq, 0);

        // 3: new edge on 7 at the same edge as the claim
        cfg_write(CFG_EDGE_SEL, 16'h0080);
        cfg_write(CFG_ENABLE, 16'h0080);
        bus.irq_src = 16'h0080;
        tick();
        bus.irq_src = '0;
        tick();
        chk("t3_irq", bus.irq, 1);
        bus.irq_src = 16'h0080;
        claim();
        bus.irq_src = '0;
        chk_claim("t3_claim", 1, 7);
        complete(4'd7);
        chk("t3_kept", bus.irq, 1);
        claim();
        chk_claim("t3_claim2", 1, 7);
        complete(4'd7);
        chk("t3_done", bus.irq, 0);

        // 4: empty claim, claim while busy, wrong complete, claim+complete together
        cfg_write(CFG_ENABLE, 16'hffff);
        claim();
        chk_claim("t4_empty", 0, 0);
        tick();
        chk("t4_ack_pulse", bus.claim_ack, 0);
        cfg_write(CFG_EDGE_SEL, 16'hffff);
        cfg_write(CFG_SW_SET, 16'h0012);
        chk("t4_irq", bus.irq, 1);
        claim();
        chk_claim("t4_claim", 1, 4);
        claim();
        chk_claim("t4_busy_claim", 0, 0);
        complete(4'd3);
        chk("t4_wrong_cmpl", bus.irq, 0);
        bus.complete_req = 1'b1; bus.complete_id = 4'd4;
        claim();
        bus.complete_req = 1'b0;
        chk_claim("t4_both", 0, 0);
        chk("t4_both_irq", bus.irq, 1);
        claim();
        chk_claim("t4_claim1", 1, 1);
        complete(4'd1);

        // 5: SW_SET 15, then reset mid-BUSY
        cfg_write(CFG_SW_SET, 16'h8000);
        chk("t5_irq", bus.irq, 1);
        claim();
        chk_claim("t5_claim", 1, 15);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_irq", bus.irq, 0);
        chk("t5_rst_ack", bus.claim_ack, 0);
        chk("t5_rst_hit", bus.claim_hit, 0);
        chk("t5_rst_id", bus.claim_id, 0);
        #3;
        rst_n = 1'b1;
        bus.irq_src = 16'hffff;
        tick();
        tick();
        chk("t5_post_irq", bus.irq, 0);
        bus.irq_src = '0;

        // random vs reference model
        do_reset();
        m_busy = 0; m_act = 0;
        for (int i = 0; i < 16; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_prev[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] src, wdata;
            logic        we, clm, cmp;
            logic [1:0]  addr;
            logic [3:0]  cid;
            int          best;
            bit          grant, e_ack, e_hit, e_irq;
            int          e_id;

            src   = 16'($urandom) & 16'($urandom);
            we    = ($urandom_range(0, 7) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = 16'($urandom);
            clm   = ($urandom_range(0, 3) == 0);
            cmp   = ($urandom_range(0, 3) == 0);
            cid   = ($urandom_range(0, 9) < 7) ? 4'(m_act) : 4'($urandom_range(0, 15));

            bus.irq_src = src; bus.cfg_we = we; bus.cfg_addr = addr; bus.cfg_wdata = wdata;
            bus.claim_req = clm; bus.complete_req = cmp; bus.complete_id = cid;

            best = -1;
            for (int i = 15; i >= 0; i--)
                if (best < 0 && m_pend[i] && m_en[i]) best = i;
            grant = !m_busy && clm && best >= 0;
            e_ack = clm;
            e_hit = grant;
            e_id  = grant ? best : 0;
            if (grant) begin
                m_busy = 1; m_act = best;
            end else if (m_busy && cmp && int'(cid) == m_act) begin
                m_busy = 0;
            end
            for (int i = 0; i < 16; i++) begin
                bit held, st;
                held = m_edge[i] && m_pend[i] && !(grant && best == i);
                st   = m_edge[i] ? (src[i] && !m_prev[i]) : src[i];
                m_pend[i] = held || st || (we && addr == 2'd2 && wdata[i]);
                m_prev[i] = src[i];
            end
            if (we && addr == 2'd0) for (int i = 0; i < 16; i++) m_en[i] = wdata[i];
            if (we && addr == 2'd1) for (int i = 0; i < 16; i++) m_edge[i] = wdata[i];
            e_irq = 0;
            for (int i = 0; i < 16; i++) if (m_pend[i] && m_en[i] && !m_busy) e_irq = 1;

            tick();
            chk($sformatf("rnd%0d_ack", c), bus.claim_ack, e_ack);
            chk($sformatf("rnd%0d_hit", c), bus.claim_hit, e_hit);
            chk($sformatf("rnd%0d_id", c), bus.claim_id, e_id);
            chk($sformatf("rnd%0d_irq", c), bus.irq, e_irq);
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
